// File: rtl/hazard_tracker_pkg.sv
// Shared pipeline types for the hazard tracker: the slot record mirrored
// beside each pipeline register, the empty-slot constant and FSM states.
package hazard_tracker_pkg;

   localparam int unsigned REG_AW = 5;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_read;
   } slot_t;

   localparam slot_t BUBBLE = '0;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } hazard_state_e;

endpackage

// File: rtl/hazard_tracker_match.sv
// Combinational check: does the decoding instruction read the destination
// of an effective (valid, writing, non-r0) writer held in one slot.
module hazard_match
   import hazard_tracker_pkg::*;
(
   input  slot_t             slot,
   input  logic              dec_valid,
   input  logic [REG_AW-1:0] dec_rs,
   input  logic [REG_AW-1:0] dec_rt,
   input  logic              dec_uses_rt,
   output logic              hit
);

   logic eff_writer;
   logic unused_slot_bits;

   always_comb begin
      eff_writer = slot.valid && slot.reg_write && (slot.rd != '0);
      hit        = eff_writer && dec_valid &&
                   ((slot.rd == dec_rs) || (dec_uses_rt && (slot.rd == dec_rt)));
   end

   assign unused_slot_bits = ^{slot.rs, slot.rt, slot.mem_read};

endmodule

// File: rtl/hazard_tracker.sv
// Shadow pipeline of in-flight register writers; feeds the forwarding unit
// and raises stall/bubble controls for load-use and unforwarded RAW hazards.
module hazard_tracker
   import hazard_tracker_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dec_valid,
   input  logic [REG_AW-1:0] dec_rs,
   input  logic [REG_AW-1:0] dec_rt,
   input  logic              dec_uses_rt,
   input  logic [REG_AW-1:0] dec_rd,
   input  logic              dec_reg_write,
   input  logic              dec_mem_read,
   input  logic              branch_flush,
   input  logic              forward_en,
   output logic              stall_pc,
   output logic              stall_if_id,
   output logic              bubble_id_ex,
   output logic [REG_AW-1:0] id_rs,
   output logic [REG_AW-1:0] id_rt,
   output logic [REG_AW-1:0] ex_rd,
   output logic [REG_AW-1:0] mem_rd,
   output logic              RegWrite_ex,
   output logic              RegWrite_mem,
   output logic              ForwardControl,
   output logic [CNT_W-1:0]  stall_count
);

   slot_t         s1, s2, s3, s1_next;
   hazard_state_e state, state_next;
   logic [2:0]    hit;
   logic          load_use, raw_nofwd, hazard, stall, bubble;

   hazard_match u_match_s1 (.slot(s1), .dec_valid(dec_valid), .dec_rs(dec_rs),
                            .dec_rt(dec_rt), .dec_uses_rt(dec_uses_rt), .hit(hit[0]));
   hazard_match u_match_s2 (.slot(s2), .dec_valid(dec_valid), .dec_rs(dec_rs),
                            .dec_rt(dec_rt), .dec_uses_rt(dec_uses_rt), .hit(hit[1]));
   hazard_match u_match_s3 (.slot(s3), .dec_valid(dec_valid), .dec_rs(dec_rs),
                            .dec_rt(dec_rt), .dec_uses_rt(dec_uses_rt), .hit(hit[2]));

   always_comb begin
      load_use  = hit[0] && s1.mem_read;
      // S3 still counts: the register file does not write through
      raw_nofwd = !forward_en && (|hit);
      hazard    = load_use || raw_nofwd;
      stall     = hazard && !branch_flush;
      bubble    = hazard || branch_flush;

      s1_next = BUBBLE;
      if (dec_valid && !bubble) begin
         s1_next.valid     = 1'b1;
         s1_next.rs        = dec_rs;
         s1_next.rt        = dec_rt;
         s1_next.rd        = dec_rd;
         s1_next.reg_write = dec_reg_write;
         s1_next.mem_read  = dec_mem_read;
      end

      state_next = state;
      case (state)
         RUN:     if (stall) state_next = STALL;
         STALL:   if (!hazard || branch_flush) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1          <= BUBBLE;
         s2          <= BUBBLE;
         s3          <= BUBBLE;
         state       <= RUN;
         stall_count <= '0;
      end else begin
         s3    <= s2;
         s2    <= s1;
         s1    <= s1_next;
         state <= state_next;
         if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      end
   end

   assign stall_pc       = stall;
   assign stall_if_id    = stall;
   assign bubble_id_ex   = bubble;
   assign id_rs          = s1.rs;
   assign id_rt          = s1.rt;
   assign ex_rd          = s2.rd;
   assign mem_rd         = s3.rd;
   assign RegWrite_ex    = s2.valid & s2.reg_write;
   assign RegWrite_mem   = s3.valid & s3.reg_write;
   assign ForwardControl = forward_en;

endmodule
